// File: rtl/lms_fir_err_stage.sv
// lms_fir_err_stage: forward path of a 4-tap LMS adaptive FIR.
// Accepts one (x_in, d_in) sample per handshake and shifts x_in into the tap
// delay line. It then runs a sequential multiply-accumulate over the four
// taps, one tap per cycle, and produces y = acc >>> Y_SHIFT and errr = d - y.
// A one-cycle err_valid pulse marks the point where xd0..xd3, y_out and errr
// are coherent.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready sample handshake; in_ready is high only while idle
//   x_in, d_in        signed 8-bit input sample and desired sample
//   hn0..hn3          signed 8-bit weights; snapshotted on accept
//   xd0..xd3          signed 8-bit delay line, xd0 newest
//   y_out             signed 18-bit filter output
//   errr              signed 10-bit error
//   err_valid         one-cycle result strobe
//
// Build option: define LMS_ERR_SAT_EN to saturate the error to [-512, 511].
// Without it, the error wraps to its low 10 bits.
module lms_fir_err_stage #(
  parameter int unsigned Y_SHIFT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  x_in,
  input  logic [7:0]  d_in,
  input  logic [7:0]  hn0,
  input  logic [7:0]  hn1,
  input  logic [7:0]  hn2,
  input  logic [7:0]  hn3,
  output logic [7:0]  xd0,
  output logic [7:0]  xd1,
  output logic [7:0]  xd2,
  output logic [7:0]  xd3,
  output logic [17:0] y_out,
  output logic [9:0]  errr,
  output logic        err_valid
);

  localparam int unsigned XW = 8;
  localparam int unsigned PW = 16;
  localparam int unsigned AW = 18;
  localparam int unsigned EW = 10;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MAC  = 2'd1;
  localparam logic [1:0] ERR  = 2'd2;

  logic [1:0]            state, state_nxt;
  logic                  accept, mac_step, err_step;
  logic [1:0]            idx;
  logic signed [AW-1:0]  acc;
  logic signed [XW-1:0]  d_lat;
  logic signed [XW-1:0]  h_snap [4];
  logic signed [XW-1:0]  tap_h, tap_x;
  logic signed [PW-1:0]  prod;
  logic signed [AW-1:0]  y_c;
  logic signed [EW-1:0]  e_red;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and per-state strobes
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    mac_step  = 1'b0;
    err_step  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = MAC;
        end
      end
      MAC: begin
        mac_step = 1'b1;
        if (idx == 2'd3) state_nxt = ERR;
      end
      ERR: begin
        err_step  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Tap select for the current MAC step (post-shift delay line)
  always_comb begin
    tap_h = h_snap[idx];
    case (idx)
      2'd0:    tap_x = $signed(xd0);
      2'd1:    tap_x = $signed(xd1);
      2'd2:    tap_x = $signed(xd2);
      default: tap_x = $signed(xd3);
    endcase
  end

  assign prod = tap_h * tap_x;
  assign y_c  = acc >>> Y_SHIFT;

  // Error reduction to 10 bits
`ifdef LMS_ERR_SAT_EN
  logic signed [AW:0] e_full;
  assign e_full = {{(AW + 1 - XW){d_lat[XW-1]}}, d_lat} - {y_c[AW-1], y_c};
  always_comb begin
    if (e_full > 19'sd511)       e_red = 10'sd511;
    else if (e_full < -19'sd512) e_red = -10'sd512;
    else                         e_red = e_full[EW-1:0];
  end
`else
  // Low 10 bits of d - y only depend on the low 10 bits of each operand
  assign e_red = {{(EW - XW){d_lat[XW-1]}}, d_lat} - y_c[EW-1:0];
`endif

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xd0       <= '0;
      xd1       <= '0;
      xd2       <= '0;
      xd3       <= '0;
      d_lat     <= '0;
      for (int i = 0; i < 4; i++) h_snap[i] <= '0;
      acc       <= '0;
      idx       <= '0;
      y_out     <= '0;
      errr      <= '0;
      err_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      err_valid <= err_step;
      in_ready  <= (state_nxt == IDLE);
      if (accept) begin
        xd3       <= xd2;
        xd2       <= xd1;
        xd1       <= xd0;
        xd0       <= x_in;
        d_lat     <= $signed(d_in);
        h_snap[0] <= $signed(hn0);
        h_snap[1] <= $signed(hn1);
        h_snap[2] <= $signed(hn2);
        h_snap[3] <= $signed(hn3);
        acc       <= '0;
        idx       <= '0;
      end
      if (mac_step) begin
        acc <= acc + {{(AW - PW){prod[PW-1]}}, prod};
        idx <= idx + 2'd1;
      end
      if (err_step) begin
        y_out <= y_c;
        errr  <= e_red;
      end
    end
  end

endmodule

// File: tb/tb_lms_fir_err_stage.sv
// Scoreboard bench for lms_fir_err_stage. A reference model accepts samples
// whenever the block is idle, computes the expected result with plain
// integer arithmetic, and queues it with its due edge. A negedge monitor
// checks in_ready every cycle and pops/compares on each err_valid.
module tb_lms_fir_err_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  x_in, d_in;
  logic [7:0]  hn0, hn1, hn2, hn3;
  logic [7:0]  xd0, xd1, xd2, xd3;
  logic [17:0] y_out;
  logic [9:0]  errr;
  logic        err_valid;

  lms_fir_err_stage #(.Y_SHIFT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .d_in(d_in), .hn0(hn0), .hn1(hn1), .hn2(hn2), .hn3(hn3),
    .xd0(xd0), .xd1(xd1), .xd2(xd2), .xd3(xd3),
    .y_out(y_out), .errr(errr), .err_valid(err_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x0, x1, x2, x3;
    int y;
    int e;
    int due;
  } exp_t;

  exp_t q[$];
  int   m_xd[4];
  int   m_busy   = 0;
  int   edge_cnt = 0;
  int   acc_cnt  = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   last_y   = 0;
  int   last_e   = 0;
  int   last_x0  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int reduce_err(input int e);
`ifdef LMS_ERR_SAT_EN
    if (e > 511)  return 511;
    if (e < -512) return -512;
    return e;
`else
    int w;
    w = e & 1023;
    if (w >= 512) w = w - 1024;
    return w;
`endif
  endfunction

  // Reference model: 4-tap FIR on a snapshot of the weights
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) m_xd[i] = 0;
      m_busy = 0;
      q.delete();
    end else begin
      edge_cnt++;
      if (m_busy > 0) begin
        m_busy--;
      end else if (in_valid) begin
        int h[4];
        int sum;
        int y;
        exp_t ex;
        h[0] = int'($signed(hn0)); h[1] = int'($signed(hn1));
        h[2] = int'($signed(hn2)); h[3] = int'($signed(hn3));
        m_xd[3] = m_xd[2]; m_xd[2] = m_xd[1]; m_xd[1] = m_xd[0];
        m_xd[0] = int'($signed(x_in));
        sum = 0;
        for (int i = 0; i < 4; i++) sum += h[i] * m_xd[i];
        y = sum >>> 4;
        ex.x0 = m_xd[0]; ex.x1 = m_xd[1]; ex.x2 = m_xd[2]; ex.x3 = m_xd[3];
        ex.y = y;
        ex.e = reduce_err(int'($signed(d_in)) - y);
        ex.due = edge_cnt + 5;
        q.push_back(ex);
        m_busy = 5;
        acc_cnt++;
      end
    end
  end

  // Monitor: handshake readiness and result strobe
  always @(negedge clk) begin
    chk("in_ready", int'(in_ready), int'(m_busy == 0));
    if (err_valid) begin
      if (q.size() == 0) begin
        chk("err_valid_spurious", 1, 0);
      end else begin
        exp_t ex;
        ex = q.pop_front();
        chk("err_valid_time", edge_cnt, ex.due);
        chk("xd0", int'($signed(xd0)), ex.x0);
        chk("xd1", int'($signed(xd1)), ex.x1);
        chk("xd2", int'($signed(xd2)), ex.x2);
        chk("xd3", int'($signed(xd3)), ex.x3);
        chk("y_out", int'($signed(y_out)), ex.y);
        chk("errr", int'($signed(errr)), ex.e);
        last_y  = int'($signed(y_out));
        last_e  = int'($signed(errr));
        last_x0 = int'($signed(xd0));
      end
    end else if (q.size() > 0 && q[0].due <= edge_cnt) begin
      exp_t ex;
      chk("err_valid_missing", 0, 1);
      ex = q.pop_front();
    end
  end

  task automatic set_h(input int a, input int b, input int c, input int d);
    hn0 = 8'(a); hn1 = 8'(b); hn2 = 8'(c); hn3 = 8'(d);
  endtask

  // Present a sample until the model reports it accepted
  task automatic send(input int x, input int d);
    int c;
    bit ok;
    c = acc_cnt;
    ok = 1'b0;
    x_in = 8'(x);
    d_in = 8'(d);
    in_valid = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (acc_cnt != c) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (q.size() == 0 && m_busy == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("drain_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_xd0"}, int'(xd0), 0);
    chk({tag, "_xd1"}, int'(xd1), 0);
    chk({tag, "_xd2"}, int'(xd2), 0);
    chk({tag, "_xd3"}, int'(xd3), 0);
    chk({tag, "_y_out"}, int'(y_out), 0);
    chk({tag, "_errr"}, int'(errr), 0);
    chk({tag, "_err_valid"}, int'(err_valid), 0);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    x_in = '0;
    d_in = '0;
    set_h(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single sample through unit weights
    set_h(1, 1, 1, 1);
    send(16, 0);
    wait_idle();
    chk("single_y", last_y, 1);
    chk("single_e", last_e, -1);
    chk("single_xd0", last_x0, 16);

    // Steady state with a full delay line
    set_h(8, 8, 8, 8);
    repeat (4) send(64, 0);
    wait_idle();
    chk("steady_y", last_y, 128);
    chk("steady_e", last_e, -128);

    // Large error exercising the 10-bit reduction
    set_h(127, 127, 127, 127);
    repeat (3) send(127, 0);
    send(127, -128);
    wait_idle();
    chk("ovf_y", last_y, 4032);
`ifdef LMS_ERR_SAT_EN
    chk("ovf_e", last_e, -512);
`else
    chk("ovf_e", last_e, -64);
`endif

    // Weight change mid-computation must not affect the running sample
    set_h(1, 1, 1, 1);
    send(10, 0);
    @(negedge clk);
    hn0 = 8'd100;
    wait_idle();
    chk("snap_cur_e", last_e, -24);
    send(10, 0);
    wait_idle();
    chk("snap_next_e", last_e, -79);

    // Continuous in_valid with x_in changing every cycle
    in_valid = 1'b1;
    for (int n = 0; n < 40; n++) begin
      x_in = 8'($urandom);
      d_in = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_idle();

    // Randomized samples, weights and gaps
    for (int n = 0; n < 30; n++) begin
      set_h(int'($urandom), int'($urandom), int'($urandom), int'($urandom));
      send(int'($urandom), int'($urandom));
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end
    wait_idle();

    // Reset asserted mid-MAC discards the sample
    set_h(3, 3, 3, 3);
    send(50, 5);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("midmac");
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("midmac_queue_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
